weight_bram_reader: RTL and testbench
=====================================

WEIGHT_BRAM_READER -- requirements
Module: weight_bram_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 28, meaning number of weight words read per pass (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter AW, default 5, meaning BRAM address width.
REQ-003 SHALL have parameter DW, default 16, meaning weight word width.
REQ-004 SHALL have port CLK  in  1  single system clock; all reader logic on rising edge.
REQ-005 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port START  in  1  one-cycle request to begin a pass; ignored while BUSY=1.
REQ-007 SHALL have port BRAM_ADDR  out  AW  read address to the weight BRAM.
REQ-008 SHALL have port BRAM_EN  out  1  BRAM enable; one read per cycle high.
REQ-009 SHALL have port BRAM_WE  out  1  BRAM write enable; constant 0.
REQ-010 SHALL have port BRAM_DI  out  DW  BRAM write data; constant 0.
REQ-011 SHALL have port BRAM_DO  in  DW  BRAM read data, updated by the BRAM on falling CLK edge after EN sampled.
REQ-012 SHALL have port W_DATA  out  DW  weight word presented downstream.
REQ-013 SHALL have port W_INDEX  out  AW  address the presented word came from.
REQ-014 SHALL have port W_VALID  out  1  W_DATA/W_INDEX/W_LAST valid.
REQ-015 SHALL have port W_READY  in  1  downstream accepts word when W_VALID=1 and W_READY=1 at rising edge.
REQ-016 SHALL have port W_LAST  out  1  presented word is index DEPTH-1.
REQ-017 SHALL have port BUSY  out  1  pass in progress.
REQ-018 SHALL have port DONE  out  1  one-cycle pulse at end of pass.

Function
REQ-019 SHALL use FSM states IDLE, RUN, FLUSH: IDLE->RUN on START; RUN->FLUSH when read of DEPTH-1 issued; FLUSH->IDLE on handshake of word with W_LAST=1.
REQ-020 SHALL, on the edge sampling START=1 in IDLE, register BRAM_EN=1, BRAM_ADDR=0, BUSY=1.
REQ-021 SHALL treat read latency as one CLK cycle: data for the address registered at edge k is written into the output buffer at edge k+1 from BRAM_DO.
REQ-022 SHALL hold words in a 2-entry FIFO output buffer; W_VALID = buffer not empty; W_DATA/W_INDEX/W_LAST from the head entry.
REQ-023 SHALL issue a read at an edge only if addresses remain and (entries held + reads outstanding) after that edge is at most 2; otherwise BRAM_EN=0 and BRAM_ADDR holds.
REQ-024 SHALL increment BRAM_ADDR by 1 per issued read; never issue an address >= DEPTH; no wrap-around within a pass.
REQ-025 SHALL sustain one word per cycle when W_READY stays 1 (first W_VALID the cycle after edge E1, where E0 sampled START).
REQ-026 SHALL keep W_DATA/W_INDEX/W_LAST stable while W_VALID=1 and W_READY=0.
REQ-027 SHALL allow push and pop on the same edge without loss or duplication.
REQ-028 SHALL pulse DONE=1 for exactly the cycle after the W_LAST handshake, with BUSY=0 in that same cycle.
REQ-029 SHALL ignore START while BUSY=1 and accept START in the DONE cycle.
REQ-030 SHALL deliver exactly DEPTH words per pass, indices 0..DEPTH-1 in order.

Reset
REQ-031 SHALL on RST_N=0, asynchronously and regardless of state: FSM=IDLE, BRAM_EN=0, BRAM_ADDR=0, BRAM_WE=0, BRAM_DI=0, W_VALID=0, W_DATA=0, W_INDEX=0, W_LAST=0, BUSY=0, DONE=0, FIFO empty, outstanding read discarded.
REQ-032 SHALL, after reset release mid-pass, remain IDLE until a new START, with no stale word presented.

Verification
REQ-033 SHALL be checked by: BRAM model mem[i]=16'h0100+i, START, W_READY=1 -> W_DATA 0x0100..0x011B on 28 consecutive cycles, W_LAST only on index 27, DONE one cycle later.
REQ-034 SHALL be checked by: W_READY=0 for 10 cycles after START -> BRAM_EN high exactly 2 cycles, W_DATA held at 0x0100; release -> remaining order intact, no duplicates.
REQ-035 SHALL be checked by: W_READY toggled randomly each cycle -> 28 words in order, BRAM_EN never asserted for address >= 28, outstanding+held never > 2.
REQ-036 SHALL be checked by: START pulsed at index 5 of a running pass -> ignored, still exactly 28 words, one DONE.
REQ-037 SHALL be checked by: RST_N low at index 12 for one cycle -> all outputs 0 immediately; new START -> pass restarts at index 0.
REQ-038 SHALL be checked by: START asserted in the DONE cycle -> second pass begins, BRAM_ADDR=0 next cycle, second DONE after 28 more words.

Source files
------------

// File: rtl/weight_bram_reader.sv
// ---------------------------------------------------------------------------
// weight_bram_reader
//
// Streams one pass of DEPTH weight words out of a synchronous weight BRAM
// and presents them downstream over a valid/ready handshake. A pass is
// started with a one-cycle START pulse. Addresses 0..DEPTH-1 are read in
// order. Each word is captured into a 2-entry output FIFO one cycle after
// its read is issued.
//
// Reads are throttled so that the words already held in the FIFO plus the
// read currently in flight never exceed the two FIFO slots. This means a
// returning word always has a free slot, and no BRAM data is ever dropped.
//
// Ports
//   CLK        system clock, all logic on the rising edge
//   RST_N      asynchronous active-low reset
//   START      one-cycle pass request, ignored while BUSY
//   BRAM_ADDR  read address to the weight BRAM
//   BRAM_EN    BRAM enable, one read per cycle it is high
//   BRAM_WE    BRAM write enable, tied low (read-only client)
//   BRAM_DI    BRAM write data, tied to zero
//   BRAM_DO    BRAM read data, valid one cycle after the read is issued
//   W_DATA     weight word at the FIFO head
//   W_INDEX    BRAM address the head word was read from
//   W_VALID    FIFO head is valid
//   W_READY    downstream accepts the head word on a rising edge
//   W_LAST     head word is the final word of the pass (index DEPTH-1)
//   BUSY       pass in progress
//   DONE       one-cycle pulse after the last word has been accepted
// ---------------------------------------------------------------------------
module weight_bram_reader #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic [AW-1:0] BRAM_ADDR,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  output logic [DW-1:0] BRAM_DI,
  input  logic [DW-1:0] BRAM_DO,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_INDEX,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The read counter is one bit wider than the address. This lets it reach
  // DEPTH even when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state;
  logic [AW:0]   rd_cnt;

  // FIFO storage. The head entry feeds the outputs directly. The tail entry
  // is only meaningful when two words are held.
  logic [1:0]    held;
  logic [DW-1:0] head_data, tail_data;
  logic [AW-1:0] head_idx, tail_idx;
  logic          head_last, tail_last;

  logic          push;
  logic          pop;
  logic          push_last;
  logic          start_pass;
  logic          issue;
  logic [AW-1:0] issue_addr;
  logic [AW:0]   rd_cnt_next;
  logic [2:0]    held_after;

  assign BRAM_WE = 1'b0;
  assign BRAM_DI = '0;

  assign W_VALID = (held != 2'd0);
  assign W_DATA  = head_data;
  assign W_INDEX = head_idx;
  assign W_LAST  = head_last;

  // Read-issue decision.
  // A read registered on the previous edge (BRAM_EN high now) always returns
  // its word at this edge, so it counts as a push. A new read may only be
  // issued if the words held after this edge, plus the new read itself,
  // still fit in the two FIFO slots. The first read of a pass is issued
  // unconditionally, because the FIFO is necessarily empty in IDLE.
  always_comb begin
    push        = BRAM_EN;
    pop         = W_VALID && W_READY;
    push_last   = (BRAM_ADDR == LAST_IDX);
    start_pass  = (state == IDLE) && START;
    held_after  = {1'b0, held} + {2'b00, push} - {2'b00, pop};
    issue       = 1'b0;
    issue_addr  = rd_cnt[AW-1:0];
    rd_cnt_next = rd_cnt + CNT_ONE;
    if (start_pass) begin
      issue       = 1'b1;
      issue_addr  = '0;
      rd_cnt_next = CNT_ONE;
    end else if ((state == RUN) && (rd_cnt < DEPTH_C) && (held_after <= 3'd1)) begin
      issue = 1'b1;
    end
  end

  // Pass sequencing and BRAM read port.
  // RUN ends as soon as the final address has been issued. FLUSH then waits
  // for that final word to drain through the FIFO. DONE is raised for the
  // cycle after the last handshake, together with BUSY dropping. Because
  // the state is already IDLE in that cycle, a START there begins the next
  // pass immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      BRAM_EN   <= 1'b0;
      BRAM_ADDR <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      BRAM_EN <= issue;
      if (issue) begin
        BRAM_ADDR <= issue_addr;
        rd_cnt    <= rd_cnt_next;
      end
      case (state)
        IDLE: begin
          if (start_pass) begin
            BUSY  <= 1'b1;
            state <= (issue_addr == LAST_IDX) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (issue && (issue_addr == LAST_IDX)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && head_last) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output FIFO, organised as a shift pair.
  // A pop moves the tail up into the head. A push lands in the first free
  // slot after any simultaneous pop has been accounted for, so a push and a
  // pop on the same edge neither lose nor duplicate a word. The issue
  // throttle guarantees that a push never arrives while both slots stay
  // occupied.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      held      <= 2'd0;
      head_data <= '0;
      head_idx  <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_idx  <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (held == 2'd0) begin
            head_data <= BRAM_DO;
            head_idx  <= BRAM_ADDR;
            head_last <= push_last;
            held      <= 2'd1;
          end else if (held == 2'd1) begin
            tail_data <= BRAM_DO;
            tail_idx  <= BRAM_ADDR;
            tail_last <= push_last;
            held      <= 2'd2;
          end
        end
        2'b01: begin
          if (held == 2'd2) begin
            head_data <= tail_data;
            head_idx  <= tail_idx;
            head_last <= tail_last;
          end
          held <= held - 2'd1;
        end
        2'b11: begin
          if (held == 2'd2) begin
            head_data <= tail_data;
            head_idx  <= tail_idx;
            head_last <= tail_last;
            tail_data <= BRAM_DO;
            tail_idx  <= BRAM_ADDR;
            tail_last <= push_last;
          end else begin
            head_data <= BRAM_DO;
            head_idx  <= BRAM_ADDR;
            head_last <= push_last;
          end
        end
        default: begin
          held <= held;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bram_reader.sv
module tb_weight_bram_reader;

  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [AW-1:0] BRAM_ADDR;
  logic          BRAM_EN;
  logic          BRAM_WE;
  logic [DW-1:0] BRAM_DI;
  logic [DW-1:0] BRAM_DO;
  logic [DW-1:0] W_DATA;
  logic [AW-1:0] W_INDEX;
  logic          W_VALID;
  logic          W_READY;
  logic          W_LAST;
  logic          BUSY;
  logic          DONE;

  int compared   = 0;
  int mismatched = 0;

  // Model state, kept in pass-level terms.
  // expIdx counts the words accepted so far. issued counts the reads seen.
  // accepted counts the handshakes seen.
  int expIdx     = 0;
  int issued     = 0;
  int accepted   = 0;
  bit busyExp    = 1'b0;
  bit expectDone = 1'b0;

  logic [DW-1:0] mem [0:31];

  weight_bram_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .BRAM_ADDR(BRAM_ADDR),
    .BRAM_EN(BRAM_EN),
    .BRAM_WE(BRAM_WE),
    .BRAM_DI(BRAM_DI),
    .BRAM_DO(BRAM_DO),
    .W_DATA(W_DATA),
    .W_INDEX(W_INDEX),
    .W_VALID(W_VALID),
    .W_READY(W_READY),
    .W_LAST(W_LAST),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Weight BRAM whose read data changes on the falling edge after the
  // enable has been registered.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
    BRAM_DO = '0;
  end

  always @(negedge CLK) begin
    if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the pass model, sampled on the
  // falling edge where inputs and outputs are both settled.
  always @(negedge CLK) begin
    if (!RST_N) begin
      checkOutput("rst_en", BRAM_EN, 0);
      checkOutput("rst_addr", BRAM_ADDR, 0);
      checkOutput("rst_valid", W_VALID, 0);
      checkOutput("rst_data", W_DATA, 0);
      checkOutput("rst_index", W_INDEX, 0);
      checkOutput("rst_last", W_LAST, 0);
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_done", DONE, 0);
      expIdx = 0; issued = 0; accepted = 0; busyExp = 0; expectDone = 0;
    end else begin
      checkOutput("busy", BUSY, busyExp);
      checkOutput("done", DONE, expectDone);
      checkOutput("we", BRAM_WE, 0);
      checkOutput("di", BRAM_DI, 0);
      if (!busyExp) checkOutput("valid_when_idle", W_VALID, 0);
      if (W_VALID) begin
        checkOutput("w_data", W_DATA, 16'h0100 + 16'(expIdx));
        checkOutput("w_index", W_INDEX, expIdx);
        checkOutput("w_last", W_LAST, (expIdx == DEPTH - 1));
      end
      if (BRAM_EN) begin
        checkOutput("rd_addr_order", BRAM_ADDR, issued);
        checkOutput("rd_addr_range", (int'(BRAM_ADDR) < DEPTH), 1);
        issued++;
        checkOutput("occupancy", ((issued - accepted) <= 2), 1);
      end
      if (expectDone) begin
        checkOutput("words_per_pass", expIdx, DEPTH);
        expIdx = 0; issued = 0; accepted = 0; expectDone = 0;
      end
      if (START && !busyExp) busyExp = 1'b1;
      if (W_VALID && W_READY) begin
        accepted++;
        if (expIdx == DEPTH - 1) begin
          expectDone = 1'b1;
          busyExp    = 1'b0;
        end
        expIdx++;
      end
    end
  end

  task automatic pulseStart();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic waitDone(input int bound, input bit randomReady, output int cycles);
    cycles = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        cycles = i;
        return;
      end
      if (randomReady) W_READY = 1'($urandom_range(0, 1));
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL done_timeout: no DONE within %0d cycles", bound);
  endtask

  task automatic waitIndex(input int idx, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge CLK); #1;
      if (W_VALID && int'(W_INDEX) == idx) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL index_timeout: index %0d never presented", idx);
  endtask

  task automatic applyStimulus();
    int cyc;
    int enCount;

    // Reset state.
    RST_N = 1'b0; START = 1'b0; W_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_valid", W_VALID, 0);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Full-rate pass.
    $display("[TB] full-rate pass");
    W_READY = 1'b1;
    pulseStart();
    checkOutput("e0_en", BRAM_EN, 1);
    checkOutput("e0_addr", BRAM_ADDR, 0);
    checkOutput("e0_busy", BUSY, 1);
    checkOutput("e0_valid", W_VALID, 0);
    @(posedge CLK); #1;
    checkOutput("e1_valid", W_VALID, 1);
    checkOutput("e1_data", W_DATA, 16'h0100);
    waitDone(60, 1'b0, cyc);
    checkOutput("fullrate_latency", cyc, 28);
    checkOutput("done_busy_low", BUSY, 0);

    // Stalled downstream.
    $display("[TB] stalled downstream");
    repeat (2) @(posedge CLK);
    #1 W_READY = 1'b0;
    pulseStart();
    enCount = 0;
    for (int i = 0; i < 10; i++) begin
      if (BRAM_EN) enCount++;
      @(posedge CLK); #1;
    end
    checkOutput("stall_en_cycles", enCount, 2);
    checkOutput("stall_valid", W_VALID, 1);
    checkOutput("stall_data", W_DATA, 16'h0100);
    W_READY = 1'b1;
    waitDone(80, 1'b0, cyc);

    // Random backpressure.
    $display("[TB] random backpressure");
    repeat (2) @(posedge CLK);
    pulseStart();
    waitDone(600, 1'b1, cyc);
    W_READY = 1'b1;

    // START during a running pass is ignored.
    $display("[TB] start while busy");
    repeat (2) @(posedge CLK);
    pulseStart();
    waitIndex(5, 40);
    START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    waitDone(60, 1'b0, cyc);
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("no_restart_busy", BUSY, 0);

    // Reset mid-pass.
    $display("[TB] reset mid-pass");
    pulseStart();
    waitIndex(12, 40);
    RST_N = 1'b0;
    #1;
    checkOutput("async_en", BRAM_EN, 0);
    checkOutput("async_valid", W_VALID, 0);
    checkOutput("async_busy", BUSY, 0);
    checkOutput("async_data", W_DATA, 0);
    checkOutput("async_index", W_INDEX, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("post_rst_busy", BUSY, 0);
    checkOutput("post_rst_valid", W_VALID, 0);
    checkOutput("post_rst_en", BRAM_EN, 0);
    pulseStart();
    checkOutput("restart_addr", BRAM_ADDR, 0);
    checkOutput("restart_en", BRAM_EN, 1);
    @(posedge CLK); #1;
    checkOutput("restart_index", W_INDEX, 0);
    checkOutput("restart_data", W_DATA, 16'h0100);
    waitDone(60, 1'b0, cyc);

    // START in the DONE cycle.
    $display("[TB] back-to-back passes");
    repeat (2) @(posedge CLK);
    pulseStart();
    waitDone(60, 1'b0, cyc);
    START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    checkOutput("b2b_addr", BRAM_ADDR, 0);
    checkOutput("b2b_en", BRAM_EN, 1);
    checkOutput("b2b_busy", BUSY, 1);
    waitDone(60, 1'b0, cyc);
    checkOutput("b2b_latency", cyc, 29);
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
